// File: rtl/led_sweep_ctrl_pkg.sv
// Shared definitions for the LED ring sweep sequencer: state encoding,
// reset pattern and counter sizing.
package led_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWEEP_L = 3'd1,
    ST_PAUSE_L = 3'd2,
    ST_SWEEP_R = 3'd3,
    ST_PAUSE_R = 3'd4
  } state_t;

  localparam logic [63:0] LED_RESET = 64'd1;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_sweep_ctrl_tick.sv
// Step-tick prescaler: single-cycle tick every TICK_CYCLES enabled clocks.
module tick_prescaler
  import led_sweep_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_width(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_sweep_ctrl.sv
// LED ring sweep sequencer: out-and-back rotation with end dwells, repeated
// for a programmed loop count, paced by the tick prescaler.
module led_sweep_ctrl
  import led_sweep_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned STEPS       = 15,
  parameter int unsigned PAUSE_TICKS = 2,
  parameter int unsigned LOOPS       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SW = cnt_width(STEPS);
  localparam int unsigned PW = cnt_width(PAUSE_TICKS);
  localparam int unsigned LW = cnt_width(LOOPS);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_TICKS - 1);
  localparam logic [LW-1:0] LOOP_LAST  = LW'(LOOPS - 1);
  localparam logic [WIDTH-1:0] LED_INIT = LED_RESET[WIDTH-1:0];

  state_t        st;
  logic [SW-1:0] step_cnt;
  logic [PW-1:0] pause_cnt;
  logic [LW-1:0] loop_cnt;
  logic          tick;
  logic          pre_en;
  logic          pre_clr;
  logic          last_loop;

  assign state     = st;
  assign pre_en    = (st != ST_IDLE) && !hold;
  assign pre_clr   = (st == ST_IDLE) || stop;
  assign last_loop = (LOOPS != 0) && (loop_cnt == LOOP_LAST);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= ST_IDLE;
      led       <= LED_INIT;
      step_cnt  <= '0;
      pause_cnt <= '0;
      loop_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st != ST_IDLE && stop) begin
        st        <= ST_IDLE;
        busy      <= 1'b0;
        step_cnt  <= '0;
        pause_cnt <= '0;
        loop_cnt  <= '0;
      end else begin
        // tick is already suppressed by hold, so hold freezes every branch
        case (st)
          ST_IDLE: begin
            if (start && !stop) begin
              st        <= ST_SWEEP_L;
              busy      <= 1'b1;
              led       <= LED_INIT;
              step_cnt  <= '0;
              pause_cnt <= '0;
              loop_cnt  <= '0;
            end
          end
          ST_SWEEP_L: begin
            if (tick) begin
              led <= {led[WIDTH-2:0], led[WIDTH-1]};
              if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                st       <= (PAUSE_TICKS == 0) ? ST_SWEEP_R : ST_PAUSE_L;
              end else begin
                step_cnt <= step_cnt + SW'(1);
              end
            end
          end
          ST_PAUSE_L: begin
            if (tick) begin
              if (pause_cnt == PAUSE_LAST) begin
                pause_cnt <= '0;
                st        <= ST_SWEEP_R;
              end else begin
                pause_cnt <= pause_cnt + PW'(1);
              end
            end
          end
          ST_SWEEP_R: begin
            if (tick) begin
              led <= {led[0], led[WIDTH-1:1]};
              if (step_cnt != STEP_LAST) begin
                step_cnt <= step_cnt + SW'(1);
              end else begin
                step_cnt <= '0;
                if (PAUSE_TICKS != 0) begin
                  st <= ST_PAUSE_R;
                end else if (last_loop) begin
                  st       <= ST_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  loop_cnt <= '0;
                end else begin
                  st       <= ST_SWEEP_L;
                  loop_cnt <= loop_cnt + LW'(1);
                end
              end
            end
          end
          ST_PAUSE_R: begin
            if (tick) begin
              if (pause_cnt != PAUSE_LAST) begin
                pause_cnt <= pause_cnt + PW'(1);
              end else begin
                pause_cnt <= '0;
                if (last_loop) begin
                  st       <= ST_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  loop_cnt <= '0;
                end else begin
                  st       <= ST_SWEEP_L;
                  loop_cnt <= loop_cnt + LW'(1);
                end
              end
            end
          end
          default: begin
            st   <= ST_IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Bench for led_sweep_ctrl: two configurations driven by shared inputs,
// checked every cycle against a tick-count reference model.
module tb_led_sweep_ctrl;

  localparam int TICK  = 4;
  localparam int STEPS = 15;
  localparam int W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [15:0] led_a, led_b;
  logic [2:0]  state_a, state_b;
  logic        busy_a, busy_b, done_a, done_b;

  always #5 clk = ~clk;

  led_sweep_ctrl #(.WIDTH(16), .TICK_CYCLES(4), .STEPS(15), .PAUSE_TICKS(2), .LOOPS(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .led(led_a), .state(state_a), .busy(busy_a), .done(done_a));

  led_sweep_ctrl #(.WIDTH(16), .TICK_CYCLES(4), .STEPS(15), .PAUSE_TICKS(0), .LOOPS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
    .led(led_b), .state(state_b), .busy(busy_b), .done(done_b));

  int n_checks = 0;
  int n_err    = 0;

  // Model: a run is described only by the number of unheld cycles since start.
  bit          m_run [2];
  int          m_a   [2];
  logic [15:0] m_led [2];
  bit          m_done[2];

  function automatic int pt(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int lp(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int per_loop(int k);
    return 2 * (STEPS + pt(k));
  endfunction

  function automatic logic [15:0] led_of(int t, int k);
    int l, p, pos;
    logic [15:0] one;
    one = 16'h0001;
    l = t % per_loop(k);
    p = pt(k);
    if (l <= STEPS) pos = l;
    else if (l <= STEPS + p) pos = STEPS;
    else if (l <= 2 * STEPS + p) pos = STEPS - (l - STEPS - p);
    else pos = 0;
    return one << (pos % W);
  endfunction

  function automatic int state_of(int k);
    int l, p;
    if (!m_run[k]) return 0;
    l = (m_a[k] / TICK) % per_loop(k);
    p = pt(k);
    if (l < STEPS) return 1;
    if (l < STEPS + p) return 2;
    if (l < 2 * STEPS + p) return 3;
    return 4;
  endfunction

  task automatic model_edge();
    int t;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (!rst) begin
        m_run[k] = 1'b0; m_a[k] = 0; m_led[k] = 16'h0001;
      end else if (!m_run[k]) begin
        if (start && !stop) begin
          m_run[k] = 1'b1; m_a[k] = 0; m_led[k] = 16'h0001;
        end
      end else if (stop) begin
        m_run[k] = 1'b0;
      end else if (!hold) begin
        m_a[k]++;
        t = m_a[k] / TICK;
        m_led[k] = led_of(t, k);
        if (lp(k) != 0 && t == lp(k) * per_loop(k)) begin
          m_run[k] = 1'b0; m_done[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("led_a",   32'(led_a),   32'(m_led[0]));
    check("state_a", 32'(state_a), 32'(state_of(0)));
    check("busy_a",  32'(busy_a),  32'(m_run[0]));
    check("done_a",  32'(done_a),  32'(m_done[0]));
    check("led_b",   32'(led_b),   32'(m_led[1]));
    check("state_b", 32'(state_b), 32'(state_of(1)));
    check("busy_b",  32'(busy_b),  32'(m_run[1]));
    check("done_b",  32'(done_b),  32'(m_done[1]));
  endtask

  task automatic set_in(input logic r, input logic s, input logic p, input logic h);
    rst = r; start = s; stop = p; hold = h;
  endtask

  task automatic restart();
    set_in(0, 0, 0, 0); step();
    set_in(1, 1, 0, 0); step();
    set_in(1, 0, 0, 0);
  endtask

  // Runs until dut_a's done pulse; 'first' is the step index of the next step.
  task automatic wait_done_a(input int first, input int exp_at, input string name);
    int at;
    at = -1;
    for (int i = first; i <= exp_at + 20; i++) begin
      step();
      if (done_a && at < 0) at = i;
    end
    check(name, 32'(at), 32'(exp_at));
  endtask

  typedef struct {
    bit rst; bit start; bit stop; bit hold;
    int cycles;
    int led; int state; bit busy; bit done;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int at, code, last, seen_pause, pulses;

    // Scenario 1: full single loop timeline on dut_a.
    vecs[0] = '{0, 0, 0, 0, 1,  'h0001, 0, 0, 0};
    vecs[1] = '{1, 1, 0, 0, 1,  'h0001, 1, 1, 0};
    vecs[2] = '{1, 0, 0, 0, 3,  'h0001, 1, 1, 0};
    vecs[3] = '{1, 0, 0, 0, 1,  'h0002, 1, 1, 0};
    vecs[4] = '{1, 0, 0, 0, 56, 'h8000, 2, 1, 0};
    vecs[5] = '{1, 0, 0, 0, 8,  'h8000, 3, 1, 0};
    vecs[6] = '{1, 0, 0, 0, 60, 'h0001, 4, 1, 0};
    vecs[7] = '{1, 0, 0, 0, 7,  'h0001, 4, 1, 0};
    vecs[8] = '{1, 0, 0, 0, 1,  'h0001, 0, 0, 1};
    vecs[9] = '{1, 0, 0, 0, 1,  'h0001, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].hold);
      repeat (vecs[i].cycles) step();
      check($sformatf("vec%0d_led", i),   32'(led_a),   32'(vecs[i].led));
      check($sformatf("vec%0d_state", i), 32'(state_a), 32'(vecs[i].state));
      check($sformatf("vec%0d_busy", i),  32'(busy_a),  32'(vecs[i].busy));
      check($sformatf("vec%0d_done", i),  32'(done_a),  32'(vecs[i].done));
    end

    // Scenario 2: stop mid SWEEP_L.
    restart();
    repeat (29) step();
    set_in(1, 0, 1, 0); step();
    set_in(1, 0, 0, 0);
    check("stop_state", 32'(state_a), 32'd0);
    check("stop_busy",  32'(busy_a),  32'd0);
    check("stop_led",   32'(led_a),   32'h0080);
    pulses = 0;
    repeat (150) begin step(); if (done_a) pulses++; end
    check("stop_no_done", 32'(pulses), 32'd0);

    // Scenario 3: hold for 20 cycles mid SWEEP_R.
    restart();
    repeat (70) step();
    set_in(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_led",   32'(led_a),   32'h8000);
      check("hold_state", 32'(state_a), 32'd3);
    end
    set_in(1, 0, 0, 0);
    step();
    check("hold_rel1_led", 32'(led_a), 32'h8000);
    step();
    check("hold_rel2_led", 32'(led_a), 32'h4000);
    wait_done_a(93, 156, "hold_done_at");

    // Scenario 4: dut_b, no dwell, two loops.
    restart();
    last = 1; code = 1; seen_pause = 0; at = -1;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (32'(state_b) != 32'(last)) begin
        last = 32'(state_b);
        code = code * 16 + last;
      end
      if (state_b == 3'd2 || state_b == 3'd4) seen_pause = 1;
      if (done_b && at < 0) at = i;
    end
    check("nopause_seq",     32'(code), 32'h13130);
    check("nopause_no_dwell", 32'(seen_pause), 32'd0);
    check("nopause_done_at", 32'(at), 32'd240);

    // Scenario 5: start+stop in IDLE, then start while busy.
    set_in(0, 0, 0, 0); step();
    set_in(1, 1, 1, 0); step();
    check("ss_state", 32'(state_a), 32'd0);
    check("ss_busy",  32'(busy_a),  32'd0);
    set_in(1, 1, 0, 0); step();
    set_in(1, 0, 0, 0);
    repeat (11) step();
    set_in(1, 1, 0, 0); step();
    set_in(1, 0, 0, 0);
    check("restart_led",   32'(led_a),   32'h0008);
    check("restart_state", 32'(state_a), 32'd1);
    wait_done_a(13, 136, "restart_done_at");

    // Scenario 6: reset during PAUSE_L, then a clean run.
    restart();
    repeat (64) step();
    check("pre_rst_state", 32'(state_a), 32'd2);
    set_in(0, 0, 0, 0); step();
    check("rst_led",   32'(led_a),   32'h0001);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    set_in(1, 1, 0, 0); step();
    set_in(1, 0, 0, 0);
    repeat (4) step();
    check("rerun_first_rot", 32'(led_a), 32'h0002);
    wait_done_a(5, 136, "rerun_done_at");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 255) != 0),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 63) == 0),
             ($urandom_range(0, 7) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/led_sweep_ctrl.md
Name: led_sweep_ctrl

Overview:
Sequencer for the board's 16-LED rotating ring. It owns the ring register, generates its own step tick from the system clock, and runs a programmed sweep: rotate toward the MSB, dwell, rotate back toward the LSB, dwell, repeated for a set loop count. Start, stop and hold come from the debounced push-button layer. led drives the LED pins directly.

Parameters:
WIDTH, 16, ring width in bits
TICK_CYCLES, 25_000_000, clk cycles per step tick; must be ≥2
STEPS, 15, rotations per sweep leg; must be ≥1
PAUSE_TICKS, 2, dwell ticks at each end; 0 means no dwell
LOOPS, 3, full out-and-back loops per start; 0 means run until stop

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  level-sampled; begins a run when idle
stop  in  1  abort run; highest priority
hold  in  1  freeze all sequencing while high
led  out  WIDTH  ring pattern
state  out  3  current FSM state code
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst==0 at a clk edge): led=1 (LSB lit), state=IDLE, busy=0, done=0, all counters 0.
- Rotation left (toward MSB): led <= {led[WIDTH-2:0], led[WIDTH-1]}. Rotation right: led <= {led[0], led[WIDTH-1:1]}.
- Prescaler: counts only in non-IDLE states with hold==0. tick=1 when the count equals TICK_CYCLES-1; the count then wraps to 0. Cleared to 0 on entry from IDLE.
- State codes: IDLE=0, SWEEP_L=1, PAUSE_L=2, SWEEP_R=3, PAUSE_R=4. Codes 5-7 are illegal and recover to IDLE on the next edge.
- IDLE: if start=1 and stop=0, next state is SWEEP_L. On that edge, led reloads to 1 and step_cnt, pause_cnt and loop_cnt clear.
- SWEEP_L: on each tick, rotate left and increment step_cnt. On the tick where step_cnt==STEPS-1, rotate, clear step_cnt, and go to PAUSE_L. If PAUSE_TICKS==0, go directly to SWEEP_R instead.
- PAUSE_L: led is static. Each tick increments pause_cnt. On the tick where pause_cnt==PAUSE_TICKS-1, clear pause_cnt and go to SWEEP_R.
- SWEEP_R and PAUSE_R mirror SWEEP_L and PAUSE_L with right rotation.
- End of PAUSE_R (or end of SWEEP_R when PAUSE_TICKS==0):
  - If LOOPS!=0 and loop_cnt==LOOPS-1: go to IDLE and pulse done high for exactly the first IDLE cycle.
  - Otherwise: increment loop_cnt and go to SWEEP_L. led is not reloaded.
- Priority: stop > hold > tick.
  - stop=1 in any non-IDLE state: next state is IDLE, led keeps its value, done stays 0, counters clear.
  - hold=1: state, led, all counters and the prescaler are frozen.
- start while busy: ignored. start and stop together in IDLE: remain IDLE.
- busy and done are registered outputs. Neither has a combinational path from inputs.
- Reset mid-run: behaves exactly as the power-on reset values above, on the next edge.
- Latency:
  - start sampled at edge N: busy=1 from N+1.
  - First rotation lands TICK_CYCLES edges after N+1.
  - One run with LOOPS=1 lasts 2*(STEPS+PAUSE_TICKS)*TICK_CYCLES cycles in non-IDLE states.

Decomposition:
- Shared package: state code localparams (ST_IDLE to ST_PAUSE_R), LED_RESET pattern, and the counter-width helper (clog2 of TICK_CYCLES, STEPS, PAUSE_TICKS, LOOPS).
- One sub-module: tick_prescaler, parameter TICK_CYCLES; ports clk, rst, en, clr, tick. It is the only clock-rate counter. Do not generate a derived clock; everything stays on clk with tick as an enable.

Test Plan:
All scenarios use TICK_CYCLES=4, STEPS=15, PAUSE_TICKS=2, LOOPS=1 unless stated.
1. Reset, then a 1-cycle start pulse -> busy=1 on next edge. led=0x0002 after 4 cycles, 0x8000 after 60 cycles in SWEEP_L, static 8 cycles in PAUSE_L. After the SWEEP_R leg led=0x0001. done pulses once 136 cycles after busy rises; busy then 0.
2. stop asserted at cycle 30 of SWEEP_L -> state=0 and busy=0 next edge. led holds its value at abort (e.g. 0x0080). done never pulses.
3. hold high for 20 cycles mid-SWEEP_R -> led, state and prescaler unchanged throughout. Completion time is shifted by exactly 20 cycles.
4. LOOPS=2, PAUSE_TICKS=0 -> sequence SWEEP_L, SWEEP_R, SWEEP_L, SWEEP_R; PAUSE states are never entered. done pulses after 240 busy cycles.
5. start and stop asserted together in IDLE -> stays IDLE. start re-asserted while busy -> no restart; counters are not cleared.
6. rst=0 for one edge during PAUSE_L -> led=0x0001, state=0, busy=0, done=0 on that edge. A fresh start then behaves as in scenario 1.
